// File: rtl/ststk_pkg.sv
// Shared definitions for the status-stack controller: field widths, field offsets and FSM encoding.
// Pure declarations; no logic, no latency.
package ststk_pkg;

    localparam int AW = 8;
    localparam int MW = 7;
    localparam int IW = 10;
    localparam int SW = AW + MW + IW;

    localparam int ASTAT_LSB = 0;
    localparam int MSTAT_LSB = 8;
    localparam int IMASK_LSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2,
        ST_RSTR = 2'd3
    } state_t;

endpackage

// File: rtl/ststk_fld.sv
// Packs {imask,mstat,astat} into a status word and splits a status word back into its fields.
// Pure combinational, zero latency, no flow control.
module ststk_fld
    import ststk_pkg::*;
(
    input  logic [AW-1:0] i_astat,
    input  logic [MW-1:0] i_mstat,
    input  logic [IW-1:0] i_imask,
    output logic [SW-1:0] o_word,
    input  logic [SW-1:0] i_word,
    output logic [AW-1:0] o_astat,
    output logic [MW-1:0] o_mstat,
    output logic [IW-1:0] o_imask
);

    always_comb begin
        o_word                       = '0;
        o_word[ASTAT_LSB +: AW]      = i_astat;
        o_word[MSTAT_LSB +: MW]      = i_mstat;
        o_word[IMASK_LSB +: IW]      = i_imask;
    end

    assign o_astat = i_word[ASTAT_LSB +: AW];
    assign o_mstat = i_word[MSTAT_LSB +: MW];
    assign o_imask = i_word[IMASK_LSB +: IW];

endmodule

// File: rtl/ststk_ctl.sv
// Status-stack sequencer: push_req->PushST_EN 1 cycle, pop_req->rst_vld 2 cycles; one pop may wait pending, excess push/pop sets sticky flags.
// FD_STS_CKGATE_EN enables the idle clock-gate request on STS_CKenb; otherwise STS_CKenb is tied 0.
module ststk_ctl
    import ststk_pkg::*;
(
    input  logic          STSCLK,
    input  logic          T_RST,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [AW-1:0] astat_i,
    input  logic [MW-1:0] mstat_i,
    input  logic [IW-1:0] imask_i,
    input  logic [SW-1:0] TopST,
    input  logic          ST_full,
    input  logic          ST_empty,
    input  logic          ST_has1,
    output logic [SW-1:0] STin,
    output logic          PushST_EN,
    output logic          PopST_EN,
    output logic          STS_CKenb,
    output logic          rst_vld,
    output logic [AW-1:0] astat_o,
    output logic [MW-1:0] mstat_o,
    output logic [IW-1:0] imask_o,
    output logic          busy,
    output logic          sts_ovf,
    output logic          sts_unf,
    output logic          last1
);

    state_t        r_state;
    state_t        w_nxt;
    logic          r_pend;
    logic          w_pend_nxt;
    logic          w_pop_take;
    logic          w_pop_direct;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic [SW-1:0] r_stin;
    logic [SW-1:0] w_pack;
    logic [AW-1:0] w_top_astat;
    logic [MW-1:0] w_top_mstat;
    logic [IW-1:0] w_top_imask;
    logic [AW-1:0] r_astat;
    logic [MW-1:0] r_mstat;
    logic [IW-1:0] r_imask;
    logic          r_ovf;
    logic          r_unf;
    logic          r_last1;

    ststk_fld u_fld (
        .i_astat (astat_i),
        .i_mstat (mstat_i),
        .i_imask (imask_i),
        .o_word  (w_pack),
        .i_word  (TopST),
        .o_astat (w_top_astat),
        .o_mstat (w_top_mstat),
        .o_imask (w_top_imask)
    );

    // Push beats pop in IDLE; a pending pop is taken straight out of PUSH.
    always_comb begin
        w_nxt      = r_state;
        w_pop_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (push_req) begin
                    w_nxt = ST_PUSH;
                end else if (pop_req || r_pend) begin
                    w_nxt      = ST_POP;
                    w_pop_take = 1'b1;
                end
            end
            ST_PUSH: begin
                if (r_pend) begin
                    w_nxt      = ST_POP;
                    w_pop_take = 1'b1;
                end else begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_POP:  w_nxt = ST_empty ? ST_IDLE : ST_RSTR;
            ST_RSTR: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop_direct = (r_state == ST_IDLE) && !push_req && !r_pend && pop_req;
        if (w_pop_take) begin
            w_pend_nxt = pop_req && !w_pop_direct;
        end else begin
            w_pend_nxt = r_pend || pop_req;
        end
        w_ovf_set = (push_req && (r_state != ST_IDLE)) ||
                    ((r_state == ST_PUSH) && ST_full);
        w_unf_set = (pop_req && r_pend && !w_pop_take) ||
                    ((r_state == ST_POP) && ST_empty);
    end

    always_ff @(posedge STSCLK or posedge T_RST) begin
        if (T_RST) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pend  <= w_pend_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge STSCLK or posedge T_RST) begin
        if (T_RST) begin
            r_stin  <= '0;
            r_astat <= '0;
            r_mstat <= '0;
            r_imask <= '0;
            r_last1 <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && push_req) begin
                r_stin <= w_pack;
            end
            if ((r_state == ST_POP) && !ST_empty) begin
                r_astat <= w_top_astat;
                r_mstat <= w_top_mstat;
                r_imask <= w_top_imask;
                r_last1 <= ST_has1;
            end
        end
    end

`ifdef FD_STS_CKGATE_EN
    logic r_ck_idle;

    // Only the quiet-IDLE level is registered; requests drop the gate combinationally.
    always_ff @(posedge STSCLK or posedge T_RST) begin
        if (T_RST) begin
            r_ck_idle <= 1'b1;
        end else begin
            r_ck_idle <= (r_state == ST_IDLE) && !r_pend && !push_req && !pop_req;
        end
    end

    assign STS_CKenb = r_ck_idle && !push_req && !pop_req;
`else
    assign STS_CKenb = 1'b0;
`endif

    assign STin      = r_stin;
    assign PushST_EN = (r_state == ST_PUSH);
    assign PopST_EN  = (r_state == ST_POP);
    assign rst_vld   = (r_state == ST_RSTR);
    assign busy      = (r_state != ST_IDLE);
    assign astat_o   = r_astat;
    assign mstat_o   = r_mstat;
    assign imask_o   = r_imask;
    assign sts_ovf   = r_ovf;
    assign sts_unf   = r_unf;
    assign last1     = r_last1;

endmodule
